// File: rtl/cbus_wide_master_pkg.sv
// Shared CBUS definitions: bus data width, command encodings and the wide-master FSM states.
package cbus_pkg;

  localparam int   CBUS_DW = 32;
  localparam logic CMD_WR  = 1'b1;
  localparam logic CMD_RD  = 1'b0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BEAT_LO = 2'd1,
    BEAT_HI = 2'd2,
    DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/cbus_wide_master_if.sv
// Host-side and CBUS-side signals of the wide master. The master modport is the block's view.
// The slave modport is the view of whoever sits around it (host engine plus CBUS slave).
interface cbus_wide_master_if #(
  parameter int DW      = 48,
  parameter int AW      = 8,
  parameter int CBUS_AW = AW + 1
);

  logic               host_req;
  logic               host_cmd;
  logic [AW-1:0]      host_addr;
  logic [DW-1:0]      host_wdata;
  logic               host_ready;
  logic               host_done;
  logic [DW-1:0]      host_rdata;
  logic               host_err;

  logic               cbus_req;
  logic               cbus_cmd;
  logic [CBUS_AW-1:0] cbus_address;
  logic [31:0]        cbus_wdata;
  logic               cbus_waccept;
  logic               cbus_rresp;
  logic [31:0]        cbus_rddata;

  modport master (
    input  host_req, host_cmd, host_addr, host_wdata,
    output host_ready, host_done, host_rdata, host_err,
    output cbus_req, cbus_cmd, cbus_address, cbus_wdata,
    input  cbus_waccept, cbus_rresp, cbus_rddata
  );

  modport slave (
    output host_req, host_cmd, host_addr, host_wdata,
    input  host_ready, host_done, host_rdata, host_err,
    input  cbus_req, cbus_cmd, cbus_address, cbus_wdata,
    output cbus_waccept, cbus_rresp, cbus_rddata
  );

endinterface

// File: rtl/cbus_wide_master.sv
// Splits one DW-bit host access into one or two 32-bit CBUS beats (low half first).
// Optional per-beat watchdog enabled by defining CBUS_MST_TIMEOUT_EN.
module cbus_wide_master
  import cbus_pkg::*;
#(
  parameter int DW             = 48,
  parameter int AW             = 8,
  parameter int CBUS_AW        = AW + 1,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic                clk,
  input logic                sreset,
  cbus_wide_master_if.master bus
);

  localparam bit TWO_BEATS = (DW > CBUS_DW);

  state_e        state_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_hi_q;
  logic [31:0]   rd_lo_q;

  logic [63:0]   wdata_ext;
  logic [DW-1:0] rd_word;
  logic          beat_done;
  logic          abort;

  assign wdata_ext = 64'(bus.host_wdata);

  // A response only counts while a beat is on the bus and only if it matches the beat's kind.
  assign beat_done = bus.cbus_req &&
                     ((bus.cbus_cmd == CMD_WR) ? bus.cbus_waccept : bus.cbus_rresp);

  // Final read word as it must look in the host_done cycle; slave bits above DW are dropped.
  always_comb begin
    if (TWO_BEATS) rd_word = DW'({bus.cbus_rddata, rd_lo_q});
    else           rd_word = DW'(bus.cbus_rddata);
  end

`ifdef CBUS_MST_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            beat_start;

  assign beat_start = ((state_q == IDLE) && bus.host_req) ||
                      ((state_q == BEAT_LO) && beat_done);
  assign abort = bus.cbus_req && !beat_done &&
                 (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (sreset || beat_start) to_cnt_q <= '0;
    else if (bus.cbus_req)    to_cnt_q <= to_cnt_q + TO_W'(1);
  end
`else
  assign abort = 1'b0;
`endif

  // NOTE: every state register uses non-blocking assignment so all of them update from
  // pre-edge values; blocking here would let later statements see half-updated state.
  always_ff @(posedge clk) begin
    if (sreset) begin
      state_q          <= IDLE;
      addr_q           <= '0;
      wdata_hi_q       <= '0;
      rd_lo_q          <= '0;
      bus.cbus_req     <= 1'b0;
      bus.cbus_cmd     <= CMD_RD;
      bus.cbus_address <= '0;
      bus.cbus_wdata   <= '0;
      bus.host_ready   <= 1'b1;
      bus.host_done    <= 1'b0;
      bus.host_rdata   <= '0;
      bus.host_err     <= 1'b0;
    end else begin
      bus.host_done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.host_req) begin
            addr_q           <= bus.host_addr;
            wdata_hi_q       <= wdata_ext[63:32];
            bus.cbus_req     <= 1'b1;
            bus.cbus_cmd     <= bus.host_cmd;
            bus.cbus_address <= CBUS_AW'({bus.host_addr, 1'b0});
            bus.cbus_wdata   <= wdata_ext[31:0];
            bus.host_ready   <= 1'b0;
            bus.host_err     <= 1'b0;
            state_q          <= BEAT_LO;
          end
        end

        BEAT_LO: begin
          if (beat_done && TWO_BEATS) begin
            rd_lo_q          <= bus.cbus_rddata;
            bus.cbus_address <= CBUS_AW'({addr_q, 1'b1});
            bus.cbus_wdata   <= wdata_hi_q;
            state_q          <= BEAT_HI;
          end else if (beat_done) begin
            bus.cbus_req  <= 1'b0;
            bus.host_done <= 1'b1;
            if (bus.cbus_cmd == CMD_RD) bus.host_rdata <= rd_word;
            state_q       <= DONE;
          end else if (abort) begin
            bus.cbus_req   <= 1'b0;
            bus.host_done  <= 1'b1;
            bus.host_err   <= 1'b1;
            bus.host_rdata <= '0;
            state_q        <= DONE;
          end
        end

        BEAT_HI: begin
          if (beat_done) begin
            bus.cbus_req  <= 1'b0;
            bus.host_done <= 1'b1;
            if (bus.cbus_cmd == CMD_RD) bus.host_rdata <= rd_word;
            state_q       <= DONE;
          end else if (abort) begin
            bus.cbus_req   <= 1'b0;
            bus.host_done  <= 1'b1;
            bus.host_err   <= 1'b1;
            bus.host_rdata <= '0;
            state_q        <= DONE;
          end
        end

        DONE: begin
          bus.host_ready <= 1'b1;
          state_q        <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cbus_wide_master.sv
// Directed self-checking bench for cbus_wide_master (DW=48, AW=8, TIMEOUT_CYCLES=16).
// The timeout scenario runs only when CBUS_MST_TIMEOUT_EN is defined.
module tb_cbus_wide_master;

  logic clk = 1'b0;
  logic sreset;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  cbus_wide_master_if #(.DW(48), .AW(8), .CBUS_AW(9)) bus ();

  cbus_wide_master #(
    .DW(48), .AW(8), .CBUS_AW(9), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk    (clk),
    .sreset (sreset),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    int pulses;
    int beats;
    int rises;
    int second_rise;
    logic prev_req;

    sreset           = 1'b1;
    bus.host_req     = 1'b0;
    bus.host_cmd     = 1'b0;
    bus.host_addr    = '0;
    bus.host_wdata   = '0;
    bus.cbus_waccept = 1'b0;
    bus.cbus_rresp   = 1'b0;
    bus.cbus_rddata  = '0;
    step();
    step();

    // Reset values
    check("rst_req",   bus.cbus_req, 0);
    check("rst_cmd",   bus.cbus_cmd, 0);
    check("rst_addr",  bus.cbus_address, 0);
    check("rst_wdata", bus.cbus_wdata, 0);
    check("rst_ready", bus.host_ready, 1);
    check("rst_done",  bus.host_done, 0);
    check("rst_rdata", bus.host_rdata, 0);
    check("rst_err",   bus.host_err, 0);
    sreset = 1'b0;
    step();

    // 1: two-beat write, zero-wait slave
    bus.cbus_waccept = 1'b1;
    bus.host_cmd     = 1'b1;
    bus.host_addr    = 8'h12;
    bus.host_wdata   = 48'hABCD_1234_5678;
    bus.host_req     = 1'b1;
    step();
    bus.host_req = 1'b0;
    check("t1_req0",   bus.cbus_req, 1);
    check("t1_cmd0",   bus.cbus_cmd, 1);
    check("t1_addr0",  bus.cbus_address, 9'h024);
    check("t1_wdata0", bus.cbus_wdata, 32'h1234_5678);
    check("t1_ready0", bus.host_ready, 0);
    step();
    check("t1_req1",   bus.cbus_req, 1);
    check("t1_addr1",  bus.cbus_address, 9'h025);
    check("t1_wdata1", bus.cbus_wdata, 32'h0000_ABCD);
    check("t1_done_early", bus.host_done, 0);
    step();
    check("t1_done",  bus.host_done, 1);
    check("t1_err",   bus.host_err, 0);
    check("t1_reqlo", bus.cbus_req, 0);
    check("t1_rdata_hold", bus.host_rdata, 0);
    step();
    check("t1_done_pulse", bus.host_done, 0);
    check("t1_ready", bus.host_ready, 1);

    // 2: two-beat read; a write accept during a read beat is ignored
    bus.host_cmd  = 1'b0;
    bus.host_addr = 8'h03;
    bus.host_req  = 1'b1;
    step();
    bus.host_req = 1'b0;
    check("t2_cmd0",  bus.cbus_cmd, 0);
    check("t2_addr0", bus.cbus_address, 9'h006);
    step();
    check("t2_wrong_kind", bus.cbus_address, 9'h006);
    bus.cbus_waccept = 1'b0;
    bus.cbus_rresp   = 1'b1;
    bus.cbus_rddata  = 32'h89AB_CDEF;
    step();
    check("t2_addr1", bus.cbus_address, 9'h007);
    bus.cbus_rddata = 32'hFFFF_4321;
    step();
    check("t2_done",  bus.host_done, 1);
    check("t2_rdata", bus.host_rdata, 48'h4321_89AB_CDEF);
    check("t2_reqlo", bus.cbus_req, 0);
    bus.cbus_rresp = 1'b0;
    step();
    check("t2_ready", bus.host_ready, 1);

    // 3: write stalled 5 cycles on beat0 with a stray read response present
    bus.host_cmd     = 1'b1;
    bus.host_addr    = 8'h7F;
    bus.host_wdata   = 48'h5A5A_DEAD_BEEF;
    bus.cbus_rresp   = 1'b1;
    bus.cbus_rddata  = 32'h1357_9BDF;
    bus.host_req     = 1'b1;
    step();
    bus.host_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t3_stall_req",   bus.cbus_req, 1);
      check("t3_stall_cmd",   bus.cbus_cmd, 1);
      check("t3_stall_addr",  bus.cbus_address, 9'h0FE);
      check("t3_stall_wdata", bus.cbus_wdata, 32'hDEAD_BEEF);
      step();
    end
    bus.cbus_waccept = 1'b1;
    check("t3_accept_addr", bus.cbus_address, 9'h0FE);
    step();
    check("t3_addr1",  bus.cbus_address, 9'h0FF);
    check("t3_wdata1", bus.cbus_wdata, 32'h0000_5A5A);
    step();
    check("t3_done", bus.host_done, 1);
    check("t3_rdata_hold", bus.host_rdata, 48'h4321_89AB_CDEF);
    bus.cbus_rresp   = 1'b0;
    bus.cbus_waccept = 1'b0;
    step();
    check("t3_ready", bus.host_ready, 1);

    // 4: reset during BEAT_HI of a read, then a clean read
    bus.host_cmd    = 1'b0;
    bus.host_addr   = 8'h40;
    bus.cbus_rresp  = 1'b1;
    bus.cbus_rddata = 32'h1111_2222;
    bus.host_req    = 1'b1;
    step();
    bus.host_req = 1'b0;
    check("t4_addr0", bus.cbus_address, 9'h080);
    step();
    check("t4_addr1", bus.cbus_address, 9'h081);
    bus.cbus_rresp = 1'b0;
    sreset         = 1'b1;
    step();
    sreset = 1'b0;
    check("t4_rst_req",   bus.cbus_req, 0);
    check("t4_rst_ready", bus.host_ready, 1);
    check("t4_rst_done",  bus.host_done, 0);
    check("t4_rst_rdata", bus.host_rdata, 0);
    step();
    check("t4_no_done", bus.host_done, 0);
    check("t4_idle_req", bus.cbus_req, 0);
    bus.host_addr   = 8'h41;
    bus.cbus_rresp  = 1'b1;
    bus.cbus_rddata = 32'h0123_4567;
    bus.host_req    = 1'b1;
    step();
    bus.host_req = 1'b0;
    check("t4b_addr0", bus.cbus_address, 9'h082);
    step();
    bus.cbus_rddata = 32'h0000_BEEF;
    step();
    check("t4b_done",  bus.host_done, 1);
    check("t4b_rdata", bus.host_rdata, 48'hBEEF_0123_4567);
    bus.cbus_rresp = 1'b0;
    step();
    check("t4b_ready", bus.host_ready, 1);

`ifdef CBUS_MST_TIMEOUT_EN
    // 5: silent slave on a read; wrong-kind accepts must not complete it
    bus.host_cmd     = 1'b0;
    bus.host_addr    = 8'h10;
    bus.cbus_waccept = 1'b1;
    bus.host_req     = 1'b1;
    step();
    bus.host_req = 1'b0;
    n = 0;
    while (bus.cbus_req && n < 40) begin
      n++;
      step();
    end
    check("t5_req_cycles", 64'(n), 16);
    check("t5_done",  bus.host_done, 1);
    check("t5_err",   bus.host_err, 1);
    check("t5_rdata", bus.host_rdata, 0);
    bus.cbus_waccept = 1'b0;
    step();
    check("t5_ready", bus.host_ready, 1);
`endif

    // 6: host_req held high across back-to-back writes
    bus.host_cmd     = 1'b1;
    bus.host_addr    = 8'h01;
    bus.host_wdata   = 48'h0000_0000_0001;
    bus.cbus_waccept = 1'b1;
    bus.host_req     = 1'b1;
    pulses      = 0;
    beats       = 0;
    rises       = 0;
    second_rise = -1;
    prev_req    = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (bus.host_done) pulses++;
      if (bus.cbus_req) beats++;
      if (bus.cbus_req && !prev_req) begin
        rises++;
        if (rises == 2) begin
          second_rise  = i;
          bus.host_req = 1'b0;
        end
      end
      prev_req = bus.cbus_req;
    end
    check("t6_done_pulses", 64'(pulses), 2);
    check("t6_beats",       64'(beats), 4);
    check("t6_second_start", 64'(second_rise), 4);
    check("t6_ready", bus.host_ready, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
